sa_core_ctrl: RTL

- Tile sequencer for a parametrised ROWS x COLS systolic core; the generalised successor to the fixed square-array fire controller.
- Runs one K-deep reduction per start command: gates fire on operand availability, drains the skew with zero injection, captures results, then unloads rows over a valid/ready port.
- Sits between the per-lane input buffers (empty/full flags in), the PE array (fire/zero_inj/capture out) and the column output stage (row select, handshake).

---
 rtl/sa_pkg.sv | 23 ++
 rtl/sa_row_unloader.sv | 36 +++
 rtl/sa_core_ctrl.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/sa_pkg.sv
// Shared definitions for the systolic tile sequencer: state encoding and
// helpers that derive the skew-drain length and counter widths.
package sa_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE    = 3'd0;
    localparam state_t ST_RUN     = 3'd1;
    localparam state_t ST_DRAIN   = 3'd2;
    localparam state_t ST_CAPTURE = 3'd3;
    localparam state_t ST_UNLOAD  = 3'd4;

    // Cycles of zero injection needed to flush the diagonal skew of the array.
    function automatic int drain_len(input int rows, input int cols);
        return rows + cols - 2;
    endfunction

    // Counter width that stays legal (>= 1 bit) even for a range of one value.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sa_row_unloader.sv
// Row unload port: presents one result row at a time over valid/ready and
// flags the acceptance of the final row.
module sa_row_unloader #(
    parameter int ROWS = 8,
    parameter int RW   = 3
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          active,
    input  logic          out_ready,
    output logic          out_valid,
    output logic [RW-1:0] out_row,
    output logic          last_accept
);

    logic [RW-1:0] row_reg;
    logic          accept;
    logic          is_last;

    assign out_valid   = active;
    assign accept      = active & out_ready;
    assign is_last     = (row_reg == RW'(ROWS - 1));
    assign last_accept = accept & is_last;
    assign out_row     = row_reg;

    // Row index advances only on a handshake and wraps to 0 after the last row,
    // so it is already 0 when the next tile begins unloading.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            row_reg <= '0;
        end else if (accept) begin
            row_reg <= is_last ? '0 : row_reg + 1'b1;
        end
    end

endmodule

// File: rtl/sa_core_ctrl.sv
// Tile sequencer for a ROWS x COLS systolic core: fires on operand
// availability, drains the skew with zero injection, captures results and
// unloads rows over valid/ready.
// Optional stall counter output perf_stall is built when SA_CTRL_PERF_EN is defined.
module sa_core_ctrl
    import sa_pkg::*;
#(
    parameter int ROWS = 8,
    parameter int COLS = 8,
    parameter int MAXK = 1024,
    parameter int KW   = $clog2(MAXK + 1)
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          start,
    input  logic [KW-1:0]                 cfg_k,
    input  logic [ROWS-1:0]               a_empty,
    input  logic [COLS-1:0]               w_empty,
    input  logic [ROWS-1:0]               a_full,
    input  logic [COLS-1:0]               w_full,
    output logic                          inp_ready,
    output logic                          fire,
    output logic                          zero_inj,
    output logic                          capture,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [cnt_width(ROWS)-1:0]    out_row,
    output logic                          busy,
    output logic                          done,
`ifdef SA_CTRL_PERF_EN
    output logic                          err_k,
    output logic [31:0]                   perf_stall
`else
    output logic                          err_k
`endif
);

    localparam int DLEN = drain_len(ROWS, COLS);
    localparam int DW   = cnt_width(DLEN + 1);
    localparam int RW   = cnt_width(ROWS);

    state_t          state_reg;
    state_t          state_next;
    logic [KW-1:0]   k_reg;
    logic [KW-1:0]   kcnt_reg;
    logic [DW-1:0]   dcnt_reg;
    logic            done_reg;
    logic            err_reg;

    logic            lanes_ready;
    logic            k_ok;
    logic            start_ok;
    logic            run_last;
    logic            last_accept;

    assign inp_ready   = ~|a_full & ~|w_full;
    assign lanes_ready = ~|a_empty & ~|w_empty;
    assign k_ok        = (cfg_k != '0) && (cfg_k <= KW'(MAXK));
    assign start_ok    = (state_reg == ST_IDLE) && start && k_ok;
    assign run_last    = (state_reg == ST_RUN) && lanes_ready && (kcnt_reg == k_reg - 1'b1);

    assign fire     = ((state_reg == ST_RUN) && lanes_ready) || (state_reg == ST_DRAIN);
    assign zero_inj = (state_reg == ST_DRAIN);
    assign capture  = (state_reg == ST_CAPTURE);
    assign busy     = (state_reg != ST_IDLE);
    assign done     = done_reg;
    assign err_k    = err_reg;

    sa_row_unloader #(
        .ROWS (ROWS),
        .RW   (RW)
    ) u_unloader (
        .clk         (clk),
        .rstn        (rstn),
        .active      (state_reg == ST_UNLOAD),
        .out_ready   (out_ready),
        .out_valid   (out_valid),
        .out_row     (out_row),
        .last_accept (last_accept)
    );

    // Next-state selection; a zero-length drain goes straight to capture.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:    if (start_ok) state_next = ST_RUN;
            ST_RUN:     if (run_last) state_next = (DLEN == 0) ? ST_CAPTURE : ST_DRAIN;
            ST_DRAIN:   if (dcnt_reg == DW'(1)) state_next = ST_CAPTURE;
            ST_CAPTURE: state_next = ST_UNLOAD;
            ST_UNLOAD:  if (last_accept) state_next = ST_IDLE;
            default:    state_next = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rstn) state_reg <= ST_IDLE;
        else       state_reg <= state_next;
    end

    // Reduction depth latch, fire counter and drain down-counter.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            k_reg    <= '0;
            kcnt_reg <= '0;
            dcnt_reg <= '0;
        end else begin
            if (start_ok) begin
                k_reg    <= cfg_k;
                kcnt_reg <= '0;
            end else if ((state_reg == ST_RUN) && lanes_ready) begin
                kcnt_reg <= kcnt_reg + 1'b1;
            end
            if (run_last)                   dcnt_reg <= DW'(DLEN);
            else if (state_reg == ST_DRAIN) dcnt_reg <= dcnt_reg - 1'b1;
        end
    end

    // Registered one-cycle status pulses: tile done and rejected start.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            done_reg <= 1'b0;
            err_reg  <= 1'b0;
        end else begin
            done_reg <= last_accept;
            err_reg  <= (state_reg == ST_IDLE) && start && !k_ok;
        end
    end

`ifdef SA_CTRL_PERF_EN
    logic [31:0] perf_reg;
    logic        stall_evt;

    assign stall_evt  = ((state_reg == ST_RUN) && !lanes_ready) ||
                        ((state_reg == ST_UNLOAD) && !out_ready);
    assign perf_stall = perf_reg;

    // Saturating stall counter, cleared when a new tile is accepted.
    always_ff @(posedge clk) begin
        if (!rstn)                             perf_reg <= '0;
        else if (start_ok)                     perf_reg <= '0;
        else if (stall_evt && perf_reg != '1)  perf_reg <= perf_reg + 1'b1;
    end
`endif

endmodule
